risc_multicycle_ctrl: RTL and testbench
=======================================

Name: risc_multicycle_ctrl

Overview:
Multi-cycle control unit for the 16-bit RISC processor. It owns the PC and fetches instructions over a req/ack instruction port. It decodes each instruction and drives the ALU operation select and datapath mux controls, then consumes the ALU zero flag to resolve branches. It sequences data-memory and register-file writeback and sits between the memories and the datapath/ALU.

Parameters:
PC_WIDTH, 16, width of PC and instruction/data addresses
INSTR_WIDTH, 16, instruction word width; opcode is always bits [INSTR_WIDTH-1 -: 4]

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  PC_WIDTH  fetch address (= pc)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  INSTR_WIDTH  fetched instruction
instr_out  out  INSTR_WIDTH  latched current instruction (register-field source for datapath)
alu_ctrl  out  3  ALU op: 000 add, 001 sub, 010 inv, 011 shl, 100 shr, 101 and, 110 or, 111 slt
alu_src_imm  out  1  1: ALU operand B = sign-extended imm6 (instr[5:0])
zero  in  1  ALU result==0 flag, combinational from ALU
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
dmem_ack  in  1  data access complete
rf_we  out  1  register-file write strobe, one cycle
wb_sel_mem  out  1  1: writeback data from dmem, 0: from ALU result register
pc_out  out  PC_WIDTH  current PC
illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Reset: clk domain only; rst sampled on rising edge, active-high, synchronous; takes priority over everything, including mid-transaction (pending req dropped, ack next cycle ignored).
- Reset values: state=IDLE, pc=0, instr_out=0, all strobes/requests 0, alu_ctrl=000, alu_src_imm=0, wb_sel_mem=0.
- Opcodes: 0 LW, 1 SW, 2 RTYPE (alu_ctrl=instr[2:0]), 3 ADDI, 4 BEQ, 5 BNE, 6 JMP, 7-15 illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB. Outputs are Moore (decoded from state + instr_out).
- IDLE -> FETCH unconditionally, one cycle after reset release.
- FETCH: imem_req=1, imem_addr=pc held stable until imem_ack. On ack, instr_out<=imem_rdata and go to DECODE. Ack while req=0 is ignored.
- DECODE:
  - JMP: pc<=zero-ext instr[11:0], go to FETCH.
  - Illegal: illegal=1 this cycle, pc<=pc+1, go to FETCH.
  - Other opcodes: go to EXEC.
- EXEC alu_ctrl / alu_src_imm:
  - RTYPE: instr[2:0] / 0.
  - ADDI, LW, SW: 000 / 1.
  - BEQ, BNE: 001 / 0.
- EXEC branches:
  - BEQ taken if zero=1; BNE taken if zero=0.
  - Taken: pc<=pc+1+sext(instr[5:0]). Not taken: pc<=pc+1.
  - Go to FETCH.
- EXEC other transitions: LW/SW -> MEM; RTYPE/ADDI -> WB.
- MEM: dmem_req=1, dmem_we=(opcode==SW), held until dmem_ack.
  - On ack, SW: pc<=pc+1, go to FETCH.
  - On ack, LW: go to WB.
- WB: rf_we=1 for exactly one cycle, wb_sel_mem=(opcode==LW), pc<=pc+1, go to FETCH.
- alu_ctrl is 000 and alu_src_imm is 0 outside EXEC.
- PC arithmetic is modulo 2^PC_WIDTH: 0xFFFF+1 wraps to 0, and negative offsets wrap.
- Latencies with 1-cycle acks, counted from first FETCH cycle to next FETCH: RTYPE/ADDI 4, BEQ/BNE 3, JMP 2, SW 4, LW 5, illegal 2.
- No instruction is retired in the same cycle as reset.

Optional Feature:
RISC_CTRL_RETIRE_CNT_EN
- Defined: adds output retire_cnt (32 bits), reset to 0. It increments by 1 on every cycle that transitions to FETCH from DECODE (JMP only), EXEC, MEM or WB. Illegal instructions do not count. It wraps 0xFFFFFFFF -> 0.
- Not defined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, imem ack 1 cycle later with RTYPE instr 0x2005 (and) -> IDLE 1 cycle, imem_req=1 addr 0. alu_ctrl=101 in EXEC, rf_we single pulse in WB, pc=1 at next FETCH.
- pc=0x0010, BEQ off6=0x3E (-2), zero=1 in EXEC -> alu_ctrl=001, next imem_addr=0x000F. Same with zero=0 -> 0x0011. BNE with zero=0 -> 0x000F.
- LW with dmem_ack delayed 3 cycles -> dmem_req/dmem_we=1/0 held 4 cycles, then WB with wb_sel_mem=1, rf_we=1 for one cycle.
- JMP instr 0x6ABC at pc=5 -> no EXEC, next imem_addr=0x0ABC. Opcode 0xF -> illegal pulse 1 cycle, pc=6, no rf_we/dmem_req.
- rst asserted while in MEM with dmem_req=1, ack arriving next cycle -> all outputs zero, pc=0, ack ignored, fetch restarts at 0.
- pc=0xFFFF ADDI retires -> next imem_addr=0x0000. With RISC_CTRL_RETIRE_CNT_EN, 10 mixed legal instrs + 1 illegal -> retire_cnt=10.

Source files
------------

// File: rtl/risc_multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit RISC core: fetch, decode, execute, memory and writeback sequencing.
// Optional retire counter output enabled by defining RISC_CTRL_RETIRE_CNT_EN.
module risc_multicycle_ctrl #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [2:0]             alu_ctrl,
    output logic                   alu_src_imm,
    input  logic                   zero,
    output logic                   dmem_req,
    output logic                   dmem_we,
    input  logic                   dmem_ack,
    output logic                   rf_we,
    output logic                   wb_sel_mem,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic                   illegal
`ifdef RISC_CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0]            retire_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;

    typedef struct packed {
        logic       imem_req;
        logic [2:0] alu_ctrl;
        logic       alu_src_imm;
        logic       dmem_req;
        logic       dmem_we;
        logic       rf_we;
        logic       wb_sel_mem;
        logic       illegal;
    } ctrl_t;

    localparam logic [3:0] OP_LW    = 4'd0;
    localparam logic [3:0] OP_SW    = 4'd1;
    localparam logic [3:0] OP_RTYPE = 4'd2;
    localparam logic [3:0] OP_ADDI  = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;
    localparam logic [3:0] OP_BNE   = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    state_t                 state, state_nxt;
    logic [PC_WIDTH-1:0]    pc, pc_nxt;
    logic [INSTR_WIDTH-1:0] instr_nxt;
    ctrl_t                  ctrl_q;

    logic [3:0]          op;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] imm_sext;
    logic [PC_WIDTH-1:0] br_tgt;
    logic [PC_WIDTH-1:0] jmp_tgt;
    logic                br_taken;

    assign op       = instr_out[INSTR_WIDTH-1 -: 4];
    assign pc_inc   = pc + PC_ONE;
    assign imm_sext = {{(PC_WIDTH-6){instr_out[5]}}, instr_out[5:0]};
    assign br_tgt   = pc_inc + imm_sext;
    assign jmp_tgt  = {{(PC_WIDTH-12){1'b0}}, instr_out[11:0]};
    assign br_taken = (op == OP_BEQ) ? zero : ~zero;

    // Output decode for a given state/instruction; evaluated on the next state so outputs are registered.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [INSTR_WIDTH-1:0] ins);
        ctrl_t      c;
        logic [3:0] o;
        c = '0;
        o = ins[INSTR_WIDTH-1 -: 4];
        case (s)
            FETCH:  c.imem_req = 1'b1;
            DECODE: c.illegal  = (o > OP_JMP);
            EXEC: begin
                case (o)
                    OP_RTYPE:             c.alu_ctrl = ins[2:0];
                    OP_ADDI, OP_LW, OP_SW: begin
                        c.alu_ctrl    = 3'b000;
                        c.alu_src_imm = 1'b1;
                    end
                    OP_BEQ, OP_BNE:       c.alu_ctrl = 3'b001;
                    default:              c.alu_ctrl = 3'b000;
                endcase
            end
            MEM: begin
                c.dmem_req = 1'b1;
                c.dmem_we  = (o == OP_SW);
            end
            WB: begin
                c.rf_we      = 1'b1;
                c.wb_sel_mem = (o == OP_LW);
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instr_out;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_nxt = imem_rdata;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (op == OP_JMP) begin
                    pc_nxt    = jmp_tgt;
                    state_nxt = FETCH;
                end else if (op > OP_JMP) begin
                    pc_nxt    = pc_inc;
                    state_nxt = FETCH;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (op == OP_BEQ || op == OP_BNE) begin
                    pc_nxt    = br_taken ? br_tgt : pc_inc;
                    state_nxt = FETCH;
                end else if (op == OP_LW || op == OP_SW) begin
                    state_nxt = MEM;
                end else begin
                    state_nxt = WB;
                end
            end
            MEM: begin
                if (dmem_ack) begin
                    if (op == OP_SW) begin
                        pc_nxt    = pc_inc;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end
            end
            WB: begin
                pc_nxt    = pc_inc;
                state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef RISC_CTRL_RETIRE_CNT_EN
    logic retire_evt;
    assign retire_evt = (state_nxt == FETCH) &&
                        ((state == EXEC) || (state == MEM) || (state == WB) ||
                         ((state == DECODE) && (op == OP_JMP)));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            instr_out <= '0;
            ctrl_q    <= '0;
`ifdef RISC_CTRL_RETIRE_CNT_EN
            retire_cnt <= '0;
`endif
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            instr_out <= instr_nxt;
            ctrl_q    <= decode_ctrl(state_nxt, instr_nxt);
`ifdef RISC_CTRL_RETIRE_CNT_EN
            if (retire_evt) retire_cnt <= retire_cnt + 32'd1;
`endif
        end
    end

    assign imem_req    = ctrl_q.imem_req;
    assign imem_addr   = pc;
    assign pc_out      = pc;
    assign alu_ctrl    = ctrl_q.alu_ctrl;
    assign alu_src_imm = ctrl_q.alu_src_imm;
    assign dmem_req    = ctrl_q.dmem_req;
    assign dmem_we     = ctrl_q.dmem_we;
    assign rf_we       = ctrl_q.rf_we;
    assign wb_sel_mem  = ctrl_q.wb_sel_mem;
    assign illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_risc_multicycle_ctrl.sv
// Scenario bench for risc_multicycle_ctrl: per-instruction scoreboard of expected control activity.
// Retire counter checks are compiled in when RISC_CTRL_RETIRE_CNT_EN is defined.
module tb_risc_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr_out;
    logic [2:0]  alu_ctrl;
    logic        alu_src_imm;
    logic        zero;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        rf_we;
    logic        wb_sel_mem;
    logic [15:0] pc_out;
    logic        illegal;
`ifdef RISC_CTRL_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] next_addr;
        logic [7:0]  lat;
        logic [2:0]  alu;
        logic        src;
        logic [7:0]  rf_cnt;
        logic [7:0]  dmem_cnt;
        logic        dmem_we;
        logic        wb_sel;
        logic [7:0]  ill_cnt;
        logic [7:0]  stray;
        logic        timeout;
    } obs_t;

    obs_t sb_q[$];

    risc_multicycle_ctrl #(.PC_WIDTH(16), .INSTR_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .alu_ctrl(alu_ctrl), .alu_src_imm(alu_src_imm), .zero(zero),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .wb_sel_mem(wb_sel_mem), .pc_out(pc_out), .illegal(illegal)
`ifdef RISC_CTRL_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t mk_exp(input logic [15:0] nxt, input int lat, input logic [2:0] alu,
                                    input logic src, input int rf, input int dm, input logic we,
                                    input logic wb, input int ill);
        obs_t e;
        e = '0;
        e.next_addr = nxt;
        e.lat       = 8'(lat);
        e.alu       = alu;
        e.src       = src;
        e.rf_cnt    = 8'(rf);
        e.dmem_cnt  = 8'(dm);
        e.dmem_we   = we;
        e.wb_sel    = wb;
        e.ill_cnt   = 8'(ill);
        return e;
    endfunction

    // Reference next-PC for one instruction.
    function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [15:0] ins, input logic z);
        logic [15:0] sx;
        sx = {{10{ins[5]}}, ins[5:0]};
        case (ins[15:12])
            4'd4:    return z  ? pc + 16'd1 + sx : pc + 16'd1;
            4'd5:    return !z ? pc + 16'd1 + sx : pc + 16'd1;
            4'd6:    return {4'h0, ins[11:0]};
            default: return pc + 16'd1;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 16'h0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic start_fresh();
        do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Runs one instruction from its FETCH to the next FETCH, recording observed control activity.
    task automatic exec_instr(input logic [15:0] ins, input logic zv, input int ack_dly,
                              input int dm_dly, output obs_t o);
        int ack_cyc, wait_i, dm_wait;
        bit fetched;
        o = '0; o.timeout = 1'b1;
        fetched = 0; wait_i = 0; dm_wait = 0; ack_cyc = -10;
        zero = zv;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (fetched && imem_req) begin
                o.next_addr = imem_addr;
                o.lat       = 8'(cyc);
                o.timeout   = 1'b0;
                break;
            end
            if (cyc == ack_cyc + 2) begin
                o.alu = alu_ctrl;
                o.src = alu_src_imm;
            end else if (alu_ctrl != 3'b000 || alu_src_imm) begin
                o.stray = o.stray + 8'd1;
            end
            if (rf_we) begin o.rf_cnt = o.rf_cnt + 8'd1; o.wb_sel = o.wb_sel | wb_sel_mem; end
            if (dmem_req) begin o.dmem_cnt = o.dmem_cnt + 8'd1; o.dmem_we = o.dmem_we | dmem_we; end
            if (illegal) o.ill_cnt = o.ill_cnt + 8'd1;
            imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = ins;
            if (!fetched && imem_req) begin
                if (wait_i == ack_dly) begin imem_ack = 1'b1; fetched = 1; ack_cyc = cyc; end
                else wait_i++;
            end
            if (dmem_req) begin
                if (dm_wait == dm_dly) dmem_ack = 1'b1;
                else dm_wait++;
            end
            @(posedge clk); #1;
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({imem_req, dmem_req, dmem_we, rf_we, wb_sel_mem, illegal, alu_ctrl, alu_src_imm, pc_out, instr_out} !== '0)
            begin n_fail++; $display("FAIL reset_state: req=%b dreq=%b rf=%b alu=%b pc=%h ins=%h, required all zero",
                                     imem_req, dmem_req, rf_we, alu_ctrl, pc_out, instr_out); end
        rst = 1'b0;
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b required 0", imem_req); end
        imem_ack = 1'b1; imem_rdata = 16'h2005;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        n_checks++;
        if ({imem_req, imem_addr, instr_out} !== {1'b1, 16'h0000, 16'h0000})
            begin n_fail++; $display("FAIL first_fetch: req=%b addr=%h ins=%h required 1/0000/0000",
                                     imem_req, imem_addr, instr_out); end
    endtask

    task automatic test_rtype_addi();
        obs_t o, e;
        sb_q.push_back(mk_exp(16'h0001, 4, 3'b101, 1'b0, 1, 0, 1'b0, 1'b0, 0));
        exec_instr(16'h2005, 1'b0, 0, 0, o);
        e = sb_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL rtype_and: got %h required %h", o, e); end
        sb_q.push_back(mk_exp(16'h0002, 4, 3'b000, 1'b1, 1, 0, 1'b0, 1'b0, 0));
        exec_instr(16'h3041, 1'b1, 0, 0, o);
        e = sb_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL addi: got %h required %h", o, e); end
        sb_q.push_back(mk_exp(16'h0003, 6, 3'b011, 1'b0, 1, 0, 1'b0, 1'b0, 0));
        exec_instr(16'h2003, 1'b0, 2, 0, o);
        e = sb_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL rtype_shl_slow_ack: got %h required %h", o, e); end
    endtask

    task automatic test_branch();
        obs_t o, e;
        logic [15:0] ins_tab[4]  = '{16'h403E, 16'h403E, 16'h503E, 16'h503E};
        logic        z_tab[4]    = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] nxt_tab[4]  = '{16'h000F, 16'h0011, 16'h000F, 16'h0011};
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back(mk_exp(16'h0010, 2, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, 0));
            exec_instr(16'h6010, 1'b0, 0, 0, o);
            e = sb_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL jmp_setup_%0d: got %h required %h", k, o, e); end
            sb_q.push_back(mk_exp(nxt_tab[k], 3, 3'b001, 1'b0, 0, 0, 1'b0, 1'b0, 0));
            exec_instr(ins_tab[k], z_tab[k], 0, 0, o);
            e = sb_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL branch_%0d: got %h required %h", k, o, e); end
        end
        sb_q.push_back(mk_exp(16'h0017, 3, 3'b001, 1'b0, 0, 0, 1'b0, 1'b0, 0));
        exec_instr(16'h4005, 1'b1, 0, 0, o);
        e = sb_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL beq_fwd: got %h required %h", o, e); end
    endtask

    task automatic test_mem();
        obs_t o, e;
        logic [15:0] base;
        base = imem_addr;
        sb_q.push_back(mk_exp(base + 16'd1, 8, 3'b000, 1'b1, 1, 4, 1'b0, 1'b1, 0));
        exec_instr(16'h0001, 1'b0, 0, 3, o);
        e = sb_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL lw_slow: got %h required %h", o, e); end
        sb_q.push_back(mk_exp(base + 16'd2, 4, 3'b000, 1'b1, 0, 1, 1'b1, 1'b0, 0));
        exec_instr(16'h1002, 1'b0, 0, 0, o);
        e = sb_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL sw_fast: got %h required %h", o, e); end
        sb_q.push_back(mk_exp(base + 16'd3, 6, 3'b000, 1'b1, 0, 3, 1'b1, 1'b0, 0));
        exec_instr(16'h1003, 1'b0, 0, 2, o);
        e = sb_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL sw_slow: got %h required %h", o, e); end
        sb_q.push_back(mk_exp(base + 16'd4, 5, 3'b000, 1'b1, 1, 1, 1'b0, 1'b1, 0));
        exec_instr(16'h0004, 1'b0, 0, 0, o);
        e = sb_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL lw_fast: got %h required %h", o, e); end
    endtask

    task automatic test_jmp_illegal();
        obs_t o, e;
        sb_q.push_back(mk_exp(16'h0005, 2, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, 0));
        exec_instr(16'h6005, 1'b0, 0, 0, o);
        e = sb_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL jmp_5: got %h required %h", o, e); end
        sb_q.push_back(mk_exp(16'h0006, 2, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, 1));
        exec_instr(16'hF123, 1'b0, 0, 0, o);
        e = sb_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL illegal_f: got %h required %h", o, e); end
        sb_q.push_back(mk_exp(16'h0ABC, 2, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, 0));
        exec_instr(16'h6ABC, 1'b0, 0, 0, o);
        e = sb_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL jmp_abc: got %h required %h", o, e); end
        sb_q.push_back(mk_exp(16'h0ABD, 2, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, 1));
        exec_instr(16'h7000, 1'b0, 0, 0, o);
        e = sb_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL illegal_7: got %h required %h", o, e); end
    endtask

    task automatic test_reset_mid_mem();
        int guard;
        bit seen_fetch;
        start_fresh();
        imem_rdata = 16'h0000;
        seen_fetch = 0;
        guard = 0;
        while (!dmem_req && guard < 20) begin
            imem_ack = imem_req && !seen_fetch;
            if (imem_req) seen_fetch = 1;
            @(posedge clk); #1;
            guard++;
        end
        imem_ack = 1'b0;
        n_checks++;
        if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL mid_mem_reach: dmem_req=%b required 1", dmem_req); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({imem_req, dmem_req, dmem_we, rf_we, wb_sel_mem, illegal, alu_ctrl, alu_src_imm, pc_out, instr_out} !== '0)
            begin n_fail++; $display("FAIL mid_mem_reset: dreq=%b rf=%b pc=%h ins=%h required all zero",
                                     dmem_req, rf_we, pc_out, instr_out); end
        rst = 1'b0; dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        n_checks++;
        if ({imem_req, imem_addr, dmem_req, rf_we} !== {1'b1, 16'h0000, 1'b0, 1'b0})
            begin n_fail++; $display("FAIL mid_mem_restart: req=%b addr=%h dreq=%b rf=%b required 1/0000/0/0",
                                     imem_req, imem_addr, dmem_req, rf_we); end
    endtask

    task automatic test_pc_wrap();
        obs_t o, e;
        start_fresh();
        sb_q.push_back(mk_exp(16'hFFFF, 3, 3'b001, 1'b0, 0, 0, 1'b0, 1'b0, 0));
        exec_instr(16'h403E, 1'b1, 0, 0, o);
        e = sb_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL beq_neg_wrap: got %h required %h", o, e); end
        sb_q.push_back(mk_exp(16'h0000, 4, 3'b000, 1'b1, 1, 0, 1'b0, 1'b0, 0));
        exec_instr(16'h3001, 1'b0, 0, 0, o);
        e = sb_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL addi_wrap: got %h required %h", o, e); end
    endtask

    task automatic test_retire_cnt();
        obs_t o, e;
        logic [15:0] prog[11] = '{16'h2001, 16'h3002, 16'h0000, 16'h1000, 16'h4002, 16'h5002,
                                  16'h6020, 16'h8000, 16'h2007, 16'h4001, 16'h3FFF};
        logic        zv[11]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [15:0] pc_m;
        start_fresh();
        pc_m = 16'h0000;
        for (int k = 0; k < 11; k++) begin
            e = '0;
            e.next_addr = model_next(pc_m, prog[k], zv[k]);
            e.ill_cnt   = (prog[k][15:12] > 4'd6) ? 8'd1 : 8'd0;
            sb_q.push_back(e);
            pc_m = e.next_addr;
            exec_instr(prog[k], zv[k], 0, 0, o);
            e = sb_q.pop_front(); n_checks++;
            if ({o.next_addr, o.ill_cnt, o.timeout} !== {e.next_addr, e.ill_cnt, 1'b0})
                begin n_fail++; $display("FAIL prog_%0d: addr=%h ill=%0d to=%b required addr=%h ill=%0d",
                                         k, o.next_addr, o.ill_cnt, o.timeout, e.next_addr, e.ill_cnt); end
        end
`ifdef RISC_CTRL_RETIRE_CNT_EN
        n_checks++;
        if (retire_cnt !== 32'd10) begin n_fail++; $display("FAIL retire_cnt: got %0d required 10", retire_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_rtype_addi();
        test_branch();
        test_mem();
        test_jmp_illegal();
        test_reset_mid_mem();
        test_pc_wrap();
        test_retire_cnt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
